// File: rtl/padin_filter.sv
// padin_filter: synchronise and debounce MIO pad inputs, serialise pad-edge events over valid/ready.
// Ports: clk_i/rst_i (sync active-high), pad_in_i raw pads, filter_en_i/debounce_cnt_i debounce control,
// in_o filtered pads, event_valid_o/event_ready_i/event_idx_o/event_rise_o edge stream,
// overflow_o/overflow_clr_i sticky merged-edge flag. Define PADIN_FILTER_SYNC3_EN for a 3-flop synchroniser.
module padin_filter #(
  parameter int NPads = 16,
  parameter int CntW = 8,
  localparam int IdxW = $clog2(NPads)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NPads-1:0] pad_in_i,
  input  logic [NPads-1:0] filter_en_i,
  input  logic [CntW-1:0]  debounce_cnt_i,
  output logic [NPads-1:0] in_o,
  output logic             event_valid_o,
  input  logic             event_ready_i,
  output logic [IdxW-1:0]  event_idx_o,
  output logic             event_rise_o,
  output logic             overflow_o,
  input  logic             overflow_clr_i
);
`ifdef PADIN_FILTER_SYNC3_EN
  localparam int SyncN = 3;
`else
  localparam int SyncN = 2;
`endif
  logic [SyncN-1:0][NPads-1:0] sync_q, sync_d;
  logic [NPads-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [NPads-1:0] sync, filt_q, filt_d, pend_q, pend_d, dir_q, dir_d, chg, drain;
  logic ev_valid_q, ev_valid_d, ev_rise_q, ev_rise_d, ovf_q, ovf_d, load, take;
  logic [IdxW-1:0] ev_idx_q, ev_idx_d, pick;
  assign sync = sync_q[SyncN-1];
  assign in_o = filt_q;
  assign event_valid_o = ev_valid_q;
  assign event_idx_o = ev_idx_q;
  assign event_rise_o = ev_rise_q;
  assign overflow_o = ovf_q;
  always_comb begin
    sync_d = {sync_q[SyncN-2:0], pad_in_i};
    filt_d = filt_q;
    cnt_d = cnt_q;
    for (int i = 0; i < NPads; i++) begin
      if (!filter_en_i[i]) begin
        filt_d[i] = sync[i];
        cnt_d[i] = '0;
      end else if (sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= debounce_cnt_i) begin
        filt_d[i] = sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + CntW'(1);
      end
    end
  end
  // Lowest-index pending pad wins; drain isolates its bit so a same-cycle new edge can re-arm it.
  always_comb begin
    pick = '0;
    for (int i = NPads - 1; i >= 0; i--) if (pend_q[i]) pick = IdxW'(i);
    chg = filt_d ^ filt_q;
    load = !ev_valid_q || event_ready_i;
    take = load && |pend_q;
    drain = take ? pend_q & (~pend_q + NPads'(1)) : '0;
    pend_d = (pend_q & ~drain) | chg;
    dir_d = (dir_q & ~chg) | (filt_d & chg);
    ovf_d = |(chg & pend_q & ~drain) || (ovf_q && !overflow_clr_i);
    ev_valid_d = load ? |pend_q : ev_valid_q;
    ev_idx_d = take ? pick : ev_idx_q;
    ev_rise_d = take ? dir_q[pick] : ev_rise_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      filt_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      dir_q <= '0;
      ev_valid_q <= 1'b0;
      ev_idx_q <= '0;
      ev_rise_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      dir_q <= dir_d;
      ev_valid_q <= ev_valid_d;
      ev_idx_q <= ev_idx_d;
      ev_rise_q <= ev_rise_d;
      ovf_q <= ovf_d;
    end
  end
endmodule

// File: tb/tb_padin_filter.sv
// tb_padin_filter: scoreboard bench for padin_filter covering reset, debounce, backpressure, overflow and reset flush.
module tb_padin_filter;
  typedef struct packed { logic [3:0] idx; logic rise; } ev_t;
  logic clk = 1'b0, rst_i = 1'b1;
  logic [15:0] pad_in_i = '0, filter_en_i = '0, in_o;
  logic [7:0] debounce_cnt_i = '0;
  logic event_valid_o, event_ready_i = 1'b0, event_rise_o, overflow_o, overflow_clr_i = 1'b0;
  logic [3:0] event_idx_o;
  ev_t exp_q[$];
  ev_t mon_e;
  int total = 0, bad = 0;
  logic stall_prev = 1'b0, prev_rise = 1'b0;
  logic [3:0] prev_idx = '0;
  padin_filter dut (
    .clk_i(clk), .rst_i(rst_i), .pad_in_i(pad_in_i), .filter_en_i(filter_en_i),
    .debounce_cnt_i(debounce_cnt_i), .in_o(in_o), .event_valid_o(event_valid_o),
    .event_ready_i(event_ready_i), .event_idx_o(event_idx_o), .event_rise_o(event_rise_o),
    .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst_i && stall_prev) begin
      total++;
      if (event_valid_o !== 1'b1 || event_idx_o !== prev_idx || event_rise_o !== prev_rise) begin
        bad++;
        $display("FAIL hold: got valid=%b idx=%0d rise=%b, want valid=1 idx=%0d rise=%b",
                 event_valid_o, event_idx_o, event_rise_o, prev_idx, prev_rise);
      end
    end
    if (!rst_i && event_valid_o === 1'b1 && event_ready_i) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL event: got unexpected idx=%0d rise=%b, want none", event_idx_o, event_rise_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (event_idx_o !== mon_e.idx || event_rise_o !== mon_e.rise) begin
          bad++;
          $display("FAIL event: got idx=%0d rise=%b, want idx=%0d rise=%b",
                   event_idx_o, event_rise_o, mon_e.idx, mon_e.rise);
        end
      end
    end
    stall_prev = !rst_i && event_valid_o === 1'b1 && !event_ready_i;
    prev_idx = event_idx_o;
    prev_rise = event_rise_o;
  end
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      cyc(1);
      k++;
    end
    cyc(2);
  endtask
  task automatic test_reset;
    logic [15:0] want;
    cyc(2);
    rst_i = 1'b0;
    total++;
    if ({in_o, event_valid_o, event_idx_o, event_rise_o, overflow_o} !== 23'd0) begin
      bad++;
      $display("FAIL reset_state: got in=%h v=%b idx=%0d r=%b ovf=%b, want all 0",
               in_o, event_valid_o, event_idx_o, event_rise_o, overflow_o);
    end
    event_ready_i = 1'b1;
    pad_in_i = 16'hFFFF;
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 1'b1});
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      want = (k == 3) ? 16'hFFFF : 16'h0000;
      total++;
      if (in_o !== want) begin
        bad++;
        $display("FAIL unfilt_latency cyc%0d: got %h want %h", k, in_o, want);
      end
    end
    wait_drain(40);
    total++;
    if (exp_q.size() != 0 || event_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rise_drain: got left=%0d valid=%b, want left=0 valid=0", exp_q.size(), event_valid_o);
    end
    pad_in_i = 16'h0000;
    for (int i = 0; i < 16; i++) exp_q.push_back({4'(i), 1'b0});
    wait_drain(40);
    total++;
    if (exp_q.size() != 0 || in_o !== 16'h0) begin
      bad++;
      $display("FAIL fall_drain: got left=%0d in=%h, want left=0 in=0000", exp_q.size(), in_o);
    end
  endtask
  task automatic test_glitch;
    filter_en_i = 16'h0008;
    debounce_cnt_i = 8'd4;
    pad_in_i = 16'h0008;
    cyc(4);
    pad_in_i = 16'h0000;
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      total++;
      if (in_o !== 16'h0) begin
        bad++;
        $display("FAIL glitch cyc%0d: got in=%h want 0000", k, in_o);
      end
    end
  endtask
  task automatic test_debounce;
    pad_in_i = 16'h0008;
    exp_q.push_back({4'd3, 1'b1});
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      total++;
      if (in_o[3] !== (k == 7)) begin
        bad++;
        $display("FAIL debounce cyc%0d: got in3=%b want %b", k, in_o[3], k == 7);
      end
    end
    wait_drain(20);
    pad_in_i = 16'h0000;
    exp_q.push_back({4'd3, 1'b0});
    cyc(8);
    wait_drain(20);
    total++;
    if (exp_q.size() != 0 || in_o !== 16'h0) begin
      bad++;
      $display("FAIL debounce_drain: got left=%0d in=%h, want left=0 in=0000", exp_q.size(), in_o);
    end
  endtask
  task automatic test_back_to_back;
    filter_en_i = '0;
    event_ready_i = 1'b0;
    pad_in_i = 16'h0004;
    exp_q.push_back({4'd2, 1'b1});
    cyc(1);
    pad_in_i = 16'h0204;
    exp_q.push_back({4'd9, 1'b1});
    cyc(6);
    total++;
    if (event_valid_o !== 1'b1 || event_idx_o !== 4'd2 || event_rise_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_first: got v=%b idx=%0d r=%b, want v=1 idx=2 r=1", event_valid_o, event_idx_o, event_rise_o);
    end
    cyc(3);
    event_ready_i = 1'b1;
    cyc(1);
    total++;
    if (event_valid_o !== 1'b1 || event_idx_o !== 4'd9 || event_rise_o !== 1'b1) begin
      bad++;
      $display("FAIL bp_second: got v=%b idx=%0d r=%b, want v=1 idx=9 r=1", event_valid_o, event_idx_o, event_rise_o);
    end
    cyc(1);
    total++;
    if (event_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop: got valid=%b want 0", event_valid_o);
    end
    pad_in_i = 16'h0000;
    exp_q.push_back({4'd2, 1'b0});
    exp_q.push_back({4'd9, 1'b0});
    wait_drain(20);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL bp_drain: got left=%0d want 0", exp_q.size());
    end
  endtask
  task automatic test_overflow;
    event_ready_i = 1'b0;
    debounce_cnt_i = 8'd2;
    pad_in_i = 16'h0002;
    exp_q.push_back({4'd1, 1'b1});
    cyc(5);
    pad_in_i = 16'h0003;
    exp_q.push_back({4'd0, 1'b1});
    cyc(5);
    filter_en_i = 16'h0020;
    pad_in_i = 16'h0023;
    cyc(8);
    total++;
    if (overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_early: got %b want 0", overflow_o);
    end
    pad_in_i = 16'h0003;
    exp_q.push_back({4'd5, 1'b0});
    cyc(8);
    total++;
    if (overflow_o !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got %b want 1", overflow_o);
    end
    overflow_clr_i = 1'b1;
    cyc(1);
    overflow_clr_i = 1'b0;
    total++;
    if (overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: got %b want 0", overflow_o);
    end
    event_ready_i = 1'b1;
    wait_drain(20);
    pad_in_i = 16'h0000;
    exp_q.push_back({4'd0, 1'b0});
    exp_q.push_back({4'd1, 1'b0});
    wait_drain(20);
    total++;
    if (exp_q.size() != 0 || overflow_o !== 1'b0) begin
      bad++;
      $display("FAIL ovf_drain: got left=%0d ovf=%b, want left=0 ovf=0", exp_q.size(), overflow_o);
    end
  endtask
  task automatic test_mid_reset;
    filter_en_i = '0;
    event_ready_i = 1'b0;
    pad_in_i = 16'h01D0;
    cyc(6);
    total++;
    if (event_valid_o !== 1'b1 || event_idx_o !== 4'd4) begin
      bad++;
      $display("FAIL mr_pre: got v=%b idx=%0d, want v=1 idx=4", event_valid_o, event_idx_o);
    end
    rst_i = 1'b1;
    pad_in_i = 16'h0000;
    cyc(1);
    total++;
    if (event_valid_o !== 1'b0 || in_o !== 16'h0) begin
      bad++;
      $display("FAIL mr_flush: got v=%b in=%h, want v=0 in=0000", event_valid_o, in_o);
    end
    rst_i = 1'b0;
    event_ready_i = 1'b1;
    cyc(20);
    total++;
    if (event_valid_o !== 1'b0 || in_o !== 16'h0 || overflow_o !== 1'b0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL mr_after: got v=%b in=%h ovf=%b left=%0d, want 0 0000 0 0",
               event_valid_o, in_o, overflow_o, exp_q.size());
    end
  endtask
  initial begin
    test_reset();
    test_glitch();
    test_debounce();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
